// File: rtl/cpu_run_monitor.sv
// Run supervisor for a small CPU core: sequences CPU reset and run, stops on
// EBREAK/ECALL/bad PC/instruction limit, and logs data stores into a show-ahead FIFO.
module cpu_run_monitor #(
  parameter int unsigned PROGRAM_WORDS    = 256,
  parameter int unsigned MAX_INSTRUCTIONS = 256,
  parameter int unsigned LOG_DEPTH        = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] instruction,
  input  logic [31:0] program_counter,
  input  logic        memory_write_en,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  output logic        cpu_reset_n,
  output logic        cpu_run,
  output logic        running,
  output logic        done,
  output logic [2:0]  stop_cause,
  output logic [31:0] stop_pc,
  output logic [15:0] instr_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_address,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = $clog2(LOG_DEPTH + 1);

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] PC_WORDS    = 32'(PROGRAM_WORDS);
  localparam logic [15:0] INSN_LIMIT  = 16'(MAX_INSTRUCTIONS);
  localparam logic [CNT_W-1:0] LOG_FULL = CNT_W'(LOG_DEPTH);

  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK   = 3'd1;
  localparam logic [2:0] CAUSE_ECALL    = 3'd2;
  localparam logic [2:0] CAUSE_RANGE    = 3'd3;
  localparam logic [2:0] CAUSE_LIMIT    = 3'd4;
  localparam logic [2:0] CAUSE_MISALIGN = 3'd5;

  typedef enum logic [1:0] {IDLE, CPU_RST, RUN, DONE} state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
  } log_entry_t;

  state_t state, next_state;
  logic   start_run;
  logic   stop_hit;
  logic [2:0] stop_code;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] log_count, count_next;
  logic push, pop, log_full, push_ok, drop;
  log_entry_t log_mem [LOG_DEPTH];
  log_entry_t head;

  // Stop conditions, highest priority first; evaluated on the live CPU inputs.
  always_comb begin
    stop_hit  = 1'b1;
    stop_code = CAUSE_NONE;
    if (program_counter[1:0] != 2'b00)
      stop_code = CAUSE_MISALIGN;
    else if ({2'b00, program_counter[31:2]} >= PC_WORDS)
      stop_code = CAUSE_RANGE;
    else if (instruction == INSN_EBREAK)
      stop_code = CAUSE_EBREAK;
    else if (instruction == INSN_ECALL)
      stop_code = CAUSE_ECALL;
    else if (instr_count == INSN_LIMIT)
      stop_code = CAUSE_LIMIT;
    else
      stop_hit = 1'b0;
  end

  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    cpu_run    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = CPU_RST;
          start_run  = 1'b1;
        end
      end
      CPU_RST: next_state = RUN;
      RUN: begin
        cpu_run = !stop_hit;
        if (stop_hit) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State-decoded outputs are registered from next_state so they track state exactly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      running     <= 1'b0;
      done        <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      state       <= next_state;
      running     <= (next_state == RUN);
      done        <= (next_state == DONE);
      cpu_reset_n <= (next_state != CPU_RST);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
      stop_cause  <= CAUSE_NONE;
      stop_pc     <= '0;
    end else if (start_run) begin
      instr_count <= '0;
      stop_cause  <= CAUSE_NONE;
      stop_pc     <= '0;
    end else begin
      if (cpu_run) instr_count <= instr_count + 16'd1;
      if (state == RUN && stop_hit) begin
        stop_cause <= stop_code;
        stop_pc    <= program_counter;
      end
    end
  end

  // A pop frees the slot in the same cycle, so a full log still accepts the store.
  always_comb begin
    push       = cpu_run && memory_write_en;
    pop        = log_valid && log_ready;
    log_full   = (log_count == LOG_FULL);
    push_ok    = push && (!log_full || pop);
    drop       = push && log_full && !pop;
    count_next = log_count + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_count    <= '0;
      log_valid    <= 1'b0;
      log_overflow <= 1'b0;
    end else if (start_run) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      log_count    <= '0;
      log_valid    <= 1'b0;
      log_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      log_count <= count_next;
      log_valid <= (count_next != '0);
      if (drop) log_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) log_mem[wr_ptr] <= '{address: memory_address, data: memory_write_value};
  end

  assign head        = log_mem[rd_ptr];
  assign log_address = head.address;
  assign log_data    = head.data;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomized self-checking bench for cpu_run_monitor against a queue-based run/log model.
module tb_cpu_run_monitor;

  localparam int unsigned PW    = 256;
  localparam int unsigned MAXI  = 256;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] instruction, program_counter, memory_address, memory_write_value;
  logic        memory_write_en, log_ready;
  logic        cpu_reset_n, cpu_run, running, done, log_valid, log_overflow;
  logic [2:0]  stop_cause;
  logic [31:0] stop_pc, log_address, log_data;
  logic [15:0] instr_count;

  cpu_run_monitor #(.PROGRAM_WORDS(PW), .MAX_INSTRUCTIONS(MAXI), .LOG_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .instruction(instruction),
    .program_counter(program_counter), .memory_write_en(memory_write_en),
    .memory_address(memory_address), .memory_write_value(memory_write_value),
    .cpu_reset_n(cpu_reset_n), .cpu_run(cpu_run), .running(running), .done(done),
    .stop_cause(stop_cause), .stop_pc(stop_pc), .instr_count(instr_count),
    .log_valid(log_valid), .log_ready(log_ready), .log_address(log_address),
    .log_data(log_data), .log_overflow(log_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   m_count;
  bit   m_ovf;
  int   n_checks = 0;
  int   n_fail   = 0;

  // One RUN cycle: predict stop/retire from the rules, compare, then advance the model.
  task automatic run_cycle(input logic [31:0] pc, input logic [31:0] ins, input bit we,
                           input logic [31:0] addr, input logic [31:0] data, input bit rdy,
                           output bit stopped);
    int   cause;
    bit   exp_run;
    ent_t e;
    program_counter = pc; instruction = ins; memory_write_en = we;
    memory_address = addr; memory_write_value = data; log_ready = rdy; start = 1'b0;
    #1;
    if (pc % 4 != 0)            cause = 5;
    else if (pc / 4 >= PW)      cause = 3;
    else if (ins == EBREAK)     cause = 1;
    else if (ins == ECALL)      cause = 2;
    else if (m_count == MAXI)   cause = 4;
    else                        cause = 0;
    exp_run = (cause == 0);
    n_checks++; if (cpu_run !== exp_run) begin n_fail++; $display("FAIL cpu_run pc=%h: got %b exp %b", pc, cpu_run, exp_run); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL running pc=%h: got %b exp 1", pc, running); end
    n_checks++; if (instr_count !== 16'(m_count)) begin n_fail++; $display("FAIL instr_count: got %0d exp %0d", instr_count, m_count); end
    n_checks++; if (log_overflow !== m_ovf) begin n_fail++; $display("FAIL log_overflow: got %b exp %b", log_overflow, m_ovf); end
    n_checks++; if (log_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL log_valid: got %b exp %b", log_valid, q.size() != 0); end
    if (q.size() != 0) begin
      n_checks++; if (log_address !== q[0].a || log_data !== q[0].d) begin
        n_fail++; $display("FAIL log_head: got %h/%h exp %h/%h", log_address, log_data, q[0].a, q[0].d);
      end
    end
    if (q.size() != 0 && rdy) void'(q.pop_front());
    if (exp_run && we) begin
      if (q.size() < DEPTH) begin e.a = addr; e.d = data; q.push_back(e); end
      else m_ovf = 1'b1;
    end
    if (exp_run) m_count++;
    @(posedge clock); #1;
    stopped = !exp_run;
    if (stopped) begin
      n_checks++; if (done !== 1'b1 || running !== 1'b0) begin n_fail++; $display("FAIL done_state: got done=%b running=%b exp 1/0", done, running); end
      n_checks++; if (stop_cause !== 3'(cause)) begin n_fail++; $display("FAIL stop_cause: got %0d exp %0d", stop_cause, cause); end
      n_checks++; if (stop_pc !== pc) begin n_fail++; $display("FAIL stop_pc: got %h exp %h", stop_pc, pc); end
      n_checks++; if (instr_count !== 16'(m_count)) begin n_fail++; $display("FAIL final_count: got %0d exp %0d", instr_count, m_count); end
    end
  endtask

  // Non-RUN cycle: CPU must stay frozen, stores ignored, log drains normally.
  task automatic idle_cycle(input bit rdy);
    log_ready = rdy; start = 1'b0; memory_write_en = 1'($urandom_range(0, 1));
    memory_address = $urandom; memory_write_value = $urandom;
    #1;
    n_checks++; if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL idle_cpu_run: got %b exp 0", cpu_run); end
    n_checks++; if (log_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL idle_log_valid: got %b exp %b", log_valid, q.size() != 0); end
    n_checks++; if (log_overflow !== m_ovf) begin n_fail++; $display("FAIL idle_overflow: got %b exp %b", log_overflow, m_ovf); end
    if (q.size() != 0) begin
      n_checks++; if (log_address !== q[0].a || log_data !== q[0].d) begin
        n_fail++; $display("FAIL idle_head: got %h/%h exp %h/%h", log_address, log_data, q[0].a, q[0].d);
      end
      if (rdy) void'(q.pop_front());
    end
    @(posedge clock); #1;
  endtask

  // Start held through CPU_RST and into RUN to show it is ignored there.
  task automatic begin_run();
    log_ready = 1'b0; memory_write_en = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    q.delete(); m_ovf = 1'b0; m_count = 0;
    n_checks++; if (cpu_reset_n !== 1'b0 || cpu_run !== 1'b0) begin n_fail++; $display("FAIL cpu_rst: got rst_n=%b run=%b exp 0/0", cpu_reset_n, cpu_run); end
    n_checks++; if (instr_count !== 16'd0 || stop_cause !== 3'd0 || stop_pc !== 32'd0) begin
      n_fail++; $display("FAIL run_clear: got cnt=%0d cause=%0d pc=%h exp 0", instr_count, stop_cause, stop_pc);
    end
    n_checks++; if (log_valid !== 1'b0 || log_overflow !== 1'b0) begin n_fail++; $display("FAIL log_flush: got v=%b ovf=%b exp 0/0", log_valid, log_overflow); end
    @(posedge clock); #1;
    start = 1'b0;
    n_checks++; if (running !== 1'b1 || cpu_reset_n !== 1'b1) begin n_fail++; $display("FAIL enter_run: got running=%b rst_n=%b exp 1/1", running, cpu_reset_n); end
  endtask

  task automatic drain_log();
    int budget = 40;
    while (q.size() != 0 && budget > 0) begin idle_cycle(1'b1); budget--; end
    n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b exp 0", log_valid); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; instruction = NOP; program_counter = '0;
    memory_write_en = 1'b0; memory_address = '0; memory_write_value = '0; log_ready = 1'b0;
    q.delete(); m_ovf = 1'b0; m_count = 0;
    #12;
    n_checks++; if (cpu_reset_n !== 1'b0 || cpu_run !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got rst_n=%b run=%b running=%b done=%b exp 0", cpu_reset_n, cpu_run, running, done);
    end
    n_checks++; if (stop_cause !== 3'd0 || stop_pc !== 32'd0 || instr_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_status: got cause=%0d pc=%h cnt=%0d exp 0", stop_cause, stop_pc, instr_count);
    end
    n_checks++; if (log_valid !== 1'b0 || log_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_log: got v=%b ovf=%b exp 0", log_valid, log_overflow); end
    @(posedge clock); #1; reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle_cycle(1'b0);
    n_checks++; if (cpu_reset_n !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL stay_idle: got rst_n=%b running=%b done=%b exp 1/0/0", cpu_reset_n, running, done);
    end
  endtask

  task automatic test_ebreak();
    bit st;
    begin_run();
    for (int i = 0; i < 3; i++) run_cycle(32'(i * 4), NOP, 1'b0, '0, '0, 1'b0, st);
    run_cycle(32'd12, EBREAK, 1'b1, 32'h55, 32'h66, 1'b0, st);
    n_checks++; if (instr_count !== 16'd3 || stop_cause !== 3'd1 || stop_pc !== 32'd12) begin
      n_fail++; $display("FAIL ebreak_run: got cnt=%0d cause=%0d pc=%h exp 3/1/c", instr_count, stop_cause, stop_pc);
    end
  endtask

  task automatic test_limit();
    bit st = 1'b0;
    begin_run();
    for (int i = 0; i < 300 && !st; i++) run_cycle(32'((i % 256) * 4), NOP, 1'b0, '0, '0, 1'b0, st);
    n_checks++; if (instr_count !== 16'd256 || stop_cause !== 3'd4) begin
      n_fail++; $display("FAIL limit_run: got cnt=%0d cause=%0d exp 256/4", instr_count, stop_cause);
    end
  endtask

  task automatic test_pc_errors();
    bit st;
    begin_run(); run_cycle(32'h400, EBREAK, 1'b0, '0, '0, 1'b0, st);
    begin_run(); run_cycle(32'h6, EBREAK, 1'b0, '0, '0, 1'b0, st);
    begin_run(); run_cycle(32'h0, NOP, 1'b0, '0, '0, 1'b0, st); run_cycle(32'h4, ECALL, 1'b0, '0, '0, 1'b0, st);
    begin_run(); run_cycle(32'h3FC, NOP, 1'b0, '0, '0, 1'b0, st); run_cycle(32'h3FC, EBREAK, 1'b0, '0, '0, 1'b0, st);
    n_checks++; if (stop_cause !== 3'd1 || stop_pc !== 32'h3FC || instr_count !== 16'd1) begin
      n_fail++; $display("FAIL last_word: got cause=%0d pc=%h cnt=%0d exp 1/3fc/1", stop_cause, stop_pc, instr_count);
    end
  endtask

  task automatic test_overflow();
    bit st;
    begin_run();
    for (int i = 0; i < 10; i++) run_cycle(32'(i * 4), NOP, 1'b1, 32'(32'h1000 + i * 4), $urandom, 1'b0, st);
    run_cycle(32'd40, EBREAK, 1'b0, '0, '0, 1'b0, st);
    n_checks++; if (log_overflow !== 1'b1 || log_address !== 32'h1000) begin
      n_fail++; $display("FAIL overflow_hold: got ovf=%b head=%h exp 1/1000", log_overflow, log_address);
    end
    drain_log();
  endtask

  task automatic test_back_to_back();
    bit st;
    begin_run();
    for (int i = 0; i < 8; i++) run_cycle(32'(i * 4), NOP, 1'b1, 32'(32'h2000 + i), $urandom, 1'b0, st);
    run_cycle(32'd32, NOP, 1'b1, 32'h2008, 32'hDEAD_BEEF, 1'b1, st);
    run_cycle(32'd36, EBREAK, 1'b0, '0, '0, 1'b0, st);
    n_checks++; if (log_overflow !== 1'b0 || log_address !== 32'h2001) begin
      n_fail++; $display("FAIL full_pop_push: got ovf=%b head=%h exp 0/2001", log_overflow, log_address);
    end
    drain_log();
  endtask

  task automatic test_mid_reset();
    bit st;
    begin_run();
    for (int i = 0; i < 3; i++) run_cycle(32'(i * 4), NOP, 1'b1, 32'(i), 32'(i), 1'b0, st);
    reset_n = 1'b0; memory_write_en = 1'b0;
    #1;
    n_checks++; if (cpu_reset_n !== 1'b0 || cpu_run !== 1'b0 || running !== 1'b0 || instr_count !== 16'd0 || log_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got rst_n=%b run=%b running=%b cnt=%0d v=%b exp 0", cpu_reset_n, cpu_run, running, instr_count, log_valid);
    end
    q.delete(); m_ovf = 1'b0; m_count = 0;
    @(posedge clock); #1; reset_n = 1'b1;
    idle_cycle(1'b0); idle_cycle(1'b0);
    begin_run();
    run_cycle(32'd0, NOP, 1'b0, '0, '0, 1'b0, st);
    run_cycle(32'd4, NOP, 1'b0, '0, '0, 1'b0, st);
    run_cycle(32'd8, EBREAK, 1'b0, '0, '0, 1'b0, st);
  endtask

  task automatic test_random();
    bit st;
    logic [31:0] pc, ins;
    int k, rdy_pct;
    for (int r = 0; r < 6; r++) begin
      begin_run();
      rdy_pct = $urandom_range(0, 80);
      st = 1'b0;
      for (int c = 0; c < 300 && !st; c++) begin
        k = $urandom_range(0, 99);
        pc = 32'($urandom_range(0, 255) * 4);
        ins = $urandom;
        if (ins == EBREAK || ins == ECALL) ins = NOP;
        if (k == 0) pc = pc + 32'($urandom_range(1, 3));
        else if (k == 1) pc = 32'(32'h400 + $urandom_range(0, 1000) * 4);
        else if (k == 2) ins = EBREAK;
        else if (k == 3) ins = ECALL;
        run_cycle(pc, ins, 1'($urandom_range(0, 1)), $urandom, $urandom,
                  ($urandom_range(0, 99) < rdy_pct), st);
      end
      for (int i = 0; i < 12; i++) idle_cycle(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_ebreak();
    test_limit();
    test_pc_errors();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
